// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM address/data port plus the decode-side valid/ready handshake and redirect.
interface instr_fetch_if #(
    parameter int AW = 7,
    parameter int IW = 18
);
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    modport master (
        output rom_addr, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready, redirect, redirect_addr
    );
    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid,
        output rom_data, instr_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, instruction register and BOOT/RUN/HALTED control feeding decode.
// Defining SINGLE_STEP_EN adds a synchronized pushbutton that releases one fetch per press.
module instr_fetch #(
    parameter int             AW        = 7,
    parameter int             IW        = 18,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter logic [IW-1:0]  HALT_WORD = '1
) (
    input  logic clk,
    input  logic reset,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    instr_fetch_if.master bus,
    output logic halted,
    output logic pc_wrap
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n, instr_pc_n;
    logic [IW-1:0] instr_n;
    logic          valid_n, pc_wrap_n, fetch_en, load;
    assign load = state == RUN && !bus.redirect && (!bus.instr_valid || bus.instr_ready) && fetch_en;
`ifdef SINGLE_STEP_EN
    logic [2:0] step_sr;
    logic       pending;
    // step_sr[1:0] synchronize, step_sr[2] is the previous level for edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            step_sr <= '0;
            pending <= 1'b0;
        end else begin
            step_sr <= {step_sr[1:0], step};
            pending <= (step_sr[1] & ~step_sr[2]) | (pending & ~load);
        end
    assign fetch_en = pending;
`else
    assign fetch_en = 1'b1;
`endif
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = bus.instr;
        instr_pc_n = bus.instr_pc;
        valid_n    = bus.instr_valid;
        pc_wrap_n  = 1'b0;
        if (state == BOOT) begin
            state_n = RUN;
        end else if (bus.redirect) begin
            pc_n    = bus.redirect_addr;
            valid_n = 1'b0;
            state_n = RUN;
        end else if (load) begin
            instr_n    = bus.rom_data;
            instr_pc_n = pc;
            valid_n    = 1'b1;
            pc_n       = pc + 1'b1;
            pc_wrap_n  = &pc;
            state_n    = bus.rom_data == HALT_WORD ? HALTED : RUN;
        end else if (bus.instr_valid && bus.instr_ready) begin
            valid_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= BOOT;
            pc              <= RESET_PC;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
            pc_wrap         <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            bus.instr       <= instr_n;
            bus.instr_pc    <= instr_pc_n;
            bus.instr_valid <= valid_n;
            pc_wrap         <= pc_wrap_n;
        end
    assign bus.rom_addr = pc;
    assign halted       = state == HALTED;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench; expected (pc, word) pairs are queued and popped on each accept.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int AW = 7;
    localparam int IW = 18;
    localparam logic [IW-1:0] HALT = '1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halted, pc_wrap;
    int vectors = 0;
    int miscompares = 0;
    int wrap_cnt = 0;
    int n;
    logic [IW-1:0] mem [2**AW];
    logic [AW+IW-1:0] exp_q [$];
    logic [AW+IW-1:0] mon_e;
    instr_fetch_if #(.AW(AW), .IW(IW)) fif ();
`ifdef SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    instr_fetch #(.AW(AW), .IW(IW)) dut (
        .clk(clk),
        .reset(reset),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .bus(fif),
        .halted(halted),
        .pc_wrap(pc_wrap)
    );
    always #5 clk = ~clk;
    assign fif.rom_data = mem[fif.rom_addr];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int pc);
        exp_q.push_back({pc[AW-1:0], mem[pc]});
    endtask
    task automatic drain(output int cnt);
        cnt = 0;
        fif.instr_ready = 1'b1;
        do begin
            tick();
            cnt++;
        end while (exp_q.size() != 0 && cnt < 60);
        fif.instr_ready = 1'b0;
        check("drain_done", {31'b0, cnt < 60}, 1);
    endtask
    task automatic jump(input int a);
        fif.redirect = 1'b1;
        fif.redirect_addr = a[AW-1:0];
        tick();
        fif.redirect = 1'b0;
    endtask
    // decode model: every accepted instruction must match the head of the queue
    always @(negedge clk) if (!reset) begin
        if (pc_wrap) begin
            wrap_cnt++;
            check("wrap_pc", {25'b0, fif.instr_pc}, 127);
        end
        if (fif.instr_valid && fif.instr_ready) begin
            check("q_nonempty", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("acc_pc", {25'b0, fif.instr_pc}, {25'b0, mon_e[AW+IW-1:IW]});
                check("acc_instr", {14'b0, fif.instr}, {14'b0, mon_e[IW-1:0]});
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = {i[6:0], ~i[6:0], 4'hA};
        mem[0] = 18'h01234;
        mem[1] = 18'h04567;
        mem[2] = 18'h089AB;
        mem[3] = 18'h0CDEF;
        fif.instr_ready = 1'b1;
        fif.redirect = 1'b0;
        fif.redirect_addr = '0;
        #2;
        check("rst_valid", {31'b0, fif.instr_valid}, 0);
        check("rst_instr", {14'b0, fif.instr}, 0);
        check("rst_pc", {25'b0, fif.instr_pc}, 0);
        check("rst_addr", {25'b0, fif.rom_addr}, 0);
        check("rst_halted", {31'b0, halted}, 0);
        check("rst_wrap", {31'b0, pc_wrap}, 0);
        tick();
        reset = 1'b0;
`ifdef SINGLE_STEP_EN
        push(0); push(1); push(2);
        repeat (3) begin
            step = 1'b1;
            repeat (5) tick();
            step = 1'b0;
            repeat (5) tick();
        end
        repeat (5) tick();
        check("step_three", exp_q.size(), 0);
        check("step_idle", {31'b0, fif.instr_valid}, 0);
        push(3);
        step = 1'b1;
        repeat (20) tick();
        step = 1'b0;
        repeat (5) tick();
        check("step_held", exp_q.size(), 0);
        check("step_addr", {25'b0, fif.rom_addr}, 4);
`else
        push(0);
        tick();
        check("boot_valid", {31'b0, fif.instr_valid}, 0);
        tick();
        check("first_valid", {31'b0, fif.instr_valid}, 1);
        check("first_pc", {25'b0, fif.instr_pc}, 0);
        drain(n);
        repeat (3) begin
            tick();
            check("stall_instr", {14'b0, fif.instr}, 32'h04567);
            check("stall_pc", {25'b0, fif.instr_pc}, 1);
            check("stall_addr", {25'b0, fif.rom_addr}, 2);
        end
        for (int i = 1; i <= 4; i++) push(i);
        drain(n);
        check("throughput", n, 4);
        check("pc5_valid", {31'b0, fif.instr_valid}, 1);
        check("pc5_held", {25'b0, fif.instr_pc}, 5);
        jump(40);
        check("redir_bubble", {31'b0, fif.instr_valid}, 0);
        check("redir_addr", {25'b0, fif.rom_addr}, 40);
        for (int i = 40; i <= 42; i++) push(i);
        drain(n);
        check("redir_lat", n, 4);
        jump(126);
        push(126); push(127); push(0);
        drain(n);
        check("wrap_cnt", wrap_cnt, 1);
        mem[3] = HALT;
        jump(0);
        for (int i = 0; i <= 3; i++) push(i);
        drain(n);
        check("halt_drained", {31'b0, fif.instr_valid}, 0);
        check("halt_flag", {31'b0, halted}, 1);
        fif.instr_ready = 1'b1;
        repeat (5) tick();
        fif.instr_ready = 1'b0;
        check("halt_idle", {31'b0, fif.instr_valid}, 0);
        check("halt_addr", {25'b0, fif.rom_addr}, 4);
        check("halt_stay", {31'b0, halted}, 1);
        jump(0);
        check("resume_halted", {31'b0, halted}, 0);
        push(0); push(1);
        drain(n);
        check("resume_pc", {25'b0, fif.instr_pc}, 2);
`endif
        reset = 1'b1;
        #1;
        check("async_valid", {31'b0, fif.instr_valid}, 0);
        check("async_instr", {14'b0, fif.instr}, 0);
        check("async_pc", {25'b0, fif.instr_pc}, 0);
        check("async_addr", {25'b0, fif.rom_addr}, 0);
        check("async_halted", {31'b0, halted}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
